// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : FSM state encodings and read/write codes for mem_arbiter
// Revision        : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    // Data-port access direction (d_rw)
    localparam logic D_RW_LOAD  = 1'b0;
    localparam logic D_RW_STORE = 1'b1;

    // Memory-port access direction (mem_rw)
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : arbitrates instruction-fetch and data requests onto one memory
//               port, with a data-run fairness limit and an access timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        d_req_i,
    input  logic        d_rw_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_done_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_rw_o,
    output logic [31:0] mem_aout_o,
    output logic [31:0] mem_dout_o,
    input  logic [31:0] mem_din_i,
    input  logic        mem_ready_i,
    output logic        stall_o,
    output logic        err_o
);

    localparam int C_RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam int C_TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [C_RUN_W-1:0] C_RUN_MAX  = C_RUN_W'(MAX_DATA_RUN);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    logic [C_RUN_W-1:0]  run_q, run_d;
    logic [C_TMO_W-1:0]  tmo_q, tmo_d;
    logic                mem_rw_q, mem_rw_d;
    logic [31:0]         mem_aout_q, mem_aout_d;
    logic [31:0]         mem_dout_q, mem_dout_d;
    logic                if_done_q, if_done_d;
    logic                d_done_q, d_done_d;
    logic [31:0]         if_data_q, if_data_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic                err_q, err_d;

    logic w_arb_en, w_grant_d, w_grant_i, w_busy, w_timeout;

    // No grant while any done pulse is out: the completing requester is still
    // holding its level, and skipping the cycle lets the run limit set the order.
    assign w_arb_en  = (state_q == ST_IDLE) && !if_done_q && !d_done_q;
    assign w_grant_d = w_arb_en && d_req_i && ((run_q < C_RUN_MAX) || !if_req_i);
    assign w_grant_i = w_arb_en && !w_grant_d && if_req_i;
    assign w_busy    = (state_q != ST_IDLE);
    assign w_timeout = w_busy && !mem_ready_i && (tmo_q == C_TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_d) begin
                    state_d = ST_BUSY_D;
                end else if (w_grant_i) begin
                    state_d = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ready_i || w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = w_busy;
        mem_rw_o   = mem_rw_q;
        mem_aout_o = mem_aout_q;
        mem_dout_o = mem_dout_q;
        if_done_o  = if_done_q;
        if_data_o  = if_data_q;
        d_done_o   = d_done_q;
        d_rdata_o  = d_rdata_q;
        err_o      = err_q;
        stall_o    = (if_req_i && !if_done_q) || (d_req_i && !d_done_q);
    end

    always_comb begin
        run_d      = run_q;
        tmo_d      = tmo_q;
        mem_rw_d   = mem_rw_q;
        mem_aout_d = mem_aout_q;
        mem_dout_d = mem_dout_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_data_d  = '0;
        d_rdata_d  = '0;
        err_d      = err_q;

        if (w_grant_d) begin
            mem_aout_d = d_addr_i;
            mem_rw_d   = (d_rw_i == D_RW_STORE) ? MEM_WRITE : MEM_READ;
            mem_dout_d = d_wdata_i;
            tmo_d      = '0;
            if (if_req_i && (run_q != C_RUN_MAX)) begin
                run_d = run_q + 1'b1;
            end
        end else if (w_grant_i) begin
            mem_aout_d = if_addr_i;
            mem_rw_d   = MEM_READ;
            mem_dout_d = '0;
            tmo_d      = '0;
            run_d      = '0;
        end

        if (!if_req_i) begin
            run_d = '0;
        end

        if (w_busy) begin
            tmo_d = tmo_q + 1'b1;
            if (mem_ready_i) begin
                if (state_q == ST_BUSY_I) begin
                    if_done_d = 1'b1;
                    if_data_d = mem_din_i;
                end else begin
                    d_done_d  = 1'b1;
                    d_rdata_d = (mem_rw_q == MEM_WRITE) ? 32'd0 : mem_din_i;
                end
            end else if (w_timeout) begin
                // Abort: complete the requester with zero data and flag it.
                if_done_d = (state_q == ST_BUSY_I);
                d_done_d  = (state_q == ST_BUSY_D);
                err_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            run_q      <= '0;
            tmo_q      <= '0;
            mem_rw_q   <= 1'b0;
            mem_aout_q <= '0;
            mem_dout_q <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_data_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            run_q      <= run_d;
            tmo_q      <= tmo_d;
            mem_rw_q   <= mem_rw_d;
            mem_aout_q <= mem_aout_d;
            mem_dout_q <= mem_dout_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_data_q  <= if_data_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed scoreboard bench for mem_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_aout;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_ready;
    logic        stall;
    logic        err;

    mem_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_done_o   (if_done),
        .if_data_o   (if_data),
        .d_req_i     (d_req),
        .d_rw_i      (d_rw),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_done_o    (d_done),
        .d_rdata_o   (d_rdata),
        .mem_req_o   (mem_req),
        .mem_rw_o    (mem_rw),
        .mem_aout_o  (mem_aout),
        .mem_dout_o  (mem_dout),
        .mem_din_i   (mem_din),
        .mem_ready_i (mem_ready),
        .stall_o     (stall),
        .err_o       (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] dout;
    } grant_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     mem_lat  = 1;
    int     last_busy_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdfn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [31:0] a, input logic rw, input logic [31:0] wd);
        grant_t g;
        g.addr = a; g.rw = rw; g.dout = wd;
        gq.push_back(g);
    endtask

    task automatic push_done(input logic is_d, input logic [31:0] data);
        done_t e;
        e.is_d = is_d; e.data = data;
        dq.push_back(e);
    endtask

    // Keep requests raised until each port has seen its quota of done pulses.
    task automatic run_until(input int nd, input int ni, input int budget);
        int sd = 0;
        int si = 0;
        int cyc = 0;
        while ((sd < nd || si < ni) && cyc < budget) begin
            tick();
            cyc++;
            if (d_done) begin
                sd++;
                if (sd >= nd) d_req = 1'b0;
            end
            if (if_done) begin
                si++;
                if (si >= ni) if_req = 1'b0;
            end
        end
        check("dones_within_budget", 32'(sd + si), 32'(nd + ni));
        d_req  = 1'b0;
        if_req = 1'b0;
    endtask

    // Memory responder: raises mem_ready in the mem_lat-th busy cycle (0 = never).
    initial begin
        int bcnt = 0;
        mem_ready = 1'b0;
        mem_din   = 32'hBAD0BAD0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                bcnt++;
                if (mem_lat != 0 && bcnt == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_din   = rdfn(mem_aout);
                end else begin
                    mem_ready = 1'b0;
                    mem_din   = 32'hBAD0BAD0;
                end
            end else begin
                bcnt      = 0;
                mem_ready = 1'b0;
                mem_din   = 32'hBAD0BAD0;
            end
        end
    end

    // Scoreboard monitor: grants and completions are compared in order.
    initial begin
        grant_t cur;
        done_t  e;
        bit     in_busy = 1'b0;
        int     busy_len = 0;
        cur.addr = '0; cur.rw = 1'b0; cur.dout = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req) begin
                    if (!in_busy) begin
                        in_busy  = 1'b1;
                        busy_len = 0;
                        check("grant_expected", 32'(gq.size() != 0), 32'd1);
                        if (gq.size() != 0) cur = gq.pop_front();
                    end
                    busy_len++;
                    check("mem_aout", mem_aout, cur.addr);
                    check("mem_rw", 32'(mem_rw), 32'(cur.rw));
                    check("mem_dout", mem_dout, cur.dout);
                end else if (in_busy) begin
                    in_busy       = 1'b0;
                    last_busy_len = busy_len;
                end
                if (if_done || d_done) begin
                    check("done_expected", 32'(dq.size() != 0), 32'd1);
                    if (dq.size() != 0) begin
                        e = dq.pop_front();
                        check("done_port", {30'd0, if_done, d_done}, e.is_d ? 32'd1 : 32'd2);
                        check("done_data", e.is_d ? d_rdata : if_data, e.data);
                    end
                end
            end else begin
                in_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_rw    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_aout", mem_aout, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fetch only, minimum latency
        mem_lat = 1;
        if_req  = 1'b1;
        if_addr = 32'h100;
        push_grant(32'h100, 1'b0, 32'd0);
        push_done(1'b0, 32'hDEADBEEF);
        @(negedge clk);
        check("fetch_c0_mem_req", 32'(mem_req), 32'd0);
        tick();
        @(negedge clk);
        check("fetch_c1_mem_req", 32'(mem_req), 32'd1);
        check("fetch_c1_stall", 32'(stall), 32'd1);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_c2_if_done", 32'(if_done), 32'd1);
        check("fetch_c2_if_data", if_data, 32'hDEADBEEF);
        check("fetch_c2_mem_req", 32'(mem_req), 32'd0);
        tick();
        @(negedge clk);
        check("fetch_c3_if_done", 32'(if_done), 32'd0);
        tick();

        // Store, memory ready in third busy cycle
        mem_lat = 3;
        d_req   = 1'b1;
        d_rw    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h12345678;
        push_grant(32'h40, 1'b1, 32'h12345678);
        push_done(1'b1, 32'd0);
        run_until(1, 0, 20);
        tick();
        @(negedge clk);
        check("store_busy_len", 32'(last_busy_len), 32'd3);
        tick();

        // Simultaneous requests: data first, then fetch
        mem_lat = 2;
        d_req   = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 32'h200;
        d_wdata = 32'h55;
        if_req  = 1'b1;
        if_addr = 32'h180;
        push_grant(32'h200, 1'b0, 32'h55);
        push_grant(32'h180, 1'b0, 32'd0);
        push_done(1'b1, rdfn(32'h200));
        push_done(1'b0, rdfn(32'h180));
        run_until(1, 1, 40);
        tick();
        tick();

        // Continuous requests: D,D,D,D,I,D
        mem_lat = 1;
        d_req   = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 32'h300;
        d_wdata = 32'd0;
        if_req  = 1'b1;
        if_addr = 32'h500;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                push_grant(32'h500, 1'b0, 32'd0);
                push_done(1'b0, rdfn(32'h500));
            end else begin
                push_grant(32'h300, 1'b0, 32'd0);
                push_done(1'b1, rdfn(32'h300));
            end
        end
        run_until(5, 1, 100);
        tick();
        tick();

        // Timeout: memory never ready
        mem_lat = 0;
        d_req   = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 32'h80;
        push_grant(32'h80, 1'b0, 32'd0);
        push_done(1'b1, 32'd0);
        run_until(1, 0, 40);
        @(negedge clk);
        check("timeout_err", 32'(err), 32'd1);
        tick();
        @(negedge clk);
        check("timeout_busy_len", 32'(last_busy_len), 32'd16);
        tick();

        // Error flag is sticky across a good access
        mem_lat = 1;
        d_req   = 1'b1;
        d_addr  = 32'h84;
        push_grant(32'h84, 1'b0, 32'd0);
        push_done(1'b1, rdfn(32'h84));
        run_until(1, 0, 20);
        tick();
        @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        tick();

        // Reset during BUSY_D aborts silently
        mem_lat = 0;
        d_req   = 1'b1;
        d_addr  = 32'h240;
        push_grant(32'h240, 1'b0, 32'd0);
        tick();
        tick();
        @(negedge clk);
        check("rst_busy_mem_req", 32'(mem_req), 32'd1);
        tick();
        rst_n = 1'b0;
        d_req = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_d_done", 32'(d_done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        tick();
        @(negedge clk);
        check("abort_d_done_later", 32'(d_done), 32'd0);
        tick();

        check("grants_consumed", 32'(gq.size()), 32'd0);
        check("dones_consumed", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
